// File: rtl/lockin_pkg.sv
// Shared types for the lock-in readout path: FIFO entry layout and read FSM states.
// READOUT_TIMESTAMP_EN adds a 32-bit timestamp field to each entry.
package lockin_pkg;

    localparam int unsigned DW   = 24;
    localparam int unsigned SEQW = 32;
`ifdef READOUT_TIMESTAMP_EN
    localparam int unsigned TSW  = 32;
`endif

    typedef struct packed {
        logic signed [DW-1:0]   x;
        logic signed [DW-1:0]   y;
        logic        [SEQW-1:0] seq;
`ifdef READOUT_TIMESTAMP_EN
        logic        [TSW-1:0]  ts;
`endif
    } readout_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        ACK
    } rd_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered fill level and a combinational head view.
// A pop and a push on a full FIFO in the same cycle both proceed; flush empties it.
module sync_fifo #(
    parameter type         T     = logic [7:0],
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  T                       wdata,
    output T                       head_c,
    output logic                   full_c,
    output logic                   empty_c,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full_c  = (level == LW'(DEPTH));
    assign empty_c = (level == '0);
    assign do_pop  = pop && !empty_c;
    assign do_push = push && (!full_c || do_pop);
    assign head_c  = mem[rd_ptr];

    // Pointer and level bookkeeping; flush has priority over traffic.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/lockin_readout_ctrl.sv
// Decimates lock-in results, queues them with a sequence index and serves them to
// software over a toggle request/ack handshake. READOUT_TIMESTAMP_EN adds ts_o.
module lockin_readout_ctrl #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 24,
    parameter int unsigned DECW  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   done_i,
    input  logic [DW-1:0]          x_i,
    input  logic [DW-1:0]          y_i,
    input  logic [DECW-1:0]        decim_i,
    input  logic                   clr_i,
    input  logic                   rd_tgl_i,
    output logic                   rd_ack_o,
    output logic [31:0]            x_o,
    output logic [31:0]            y_o,
    output logic [31:0]            seq_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   overflow_o,
    output logic [15:0]            drops_o,
    output logic [31:0]            ts_o
);

    import lockin_pkg::*;

    logic [SEQW-1:0] raw_idx;
    logic [DECW-1:0] dec_cnt;
    logic [DECW-1:0] dec_lim;
    logic [DECW-1:0] lim_now_c;
    logic            keep_c;
    logic            push_c;
    logic            drop_c;
    logic            pop_c;
    logic            full_c;
    logic            empty_c;
    readout_entry_t  wr_entry_c;
    readout_entry_t  head_c;
    rd_state_t       state;
    rd_state_t       state_d;
    logic            rd_tgl_q;

`ifdef READOUT_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
        end
    end
`else
    assign ts_o = '0;
`endif

    // The wrap limit is sampled from decim_i only when a new period starts.
    always_comb begin
        lim_now_c = dec_lim;
        if (dec_cnt == '0) begin
            lim_now_c = (decim_i == '0) ? '0 : decim_i - DECW'(1);
        end
    end

    assign keep_c = done_i && (dec_cnt == '0);
    assign push_c = keep_c && !clr_i && (!full_c || pop_c);
    assign drop_c = keep_c && !clr_i && full_c && !pop_c;

    always_comb begin
        wr_entry_c     = '0;
        wr_entry_c.x   = x_i;
        wr_entry_c.y   = y_i;
        wr_entry_c.seq = raw_idx;
`ifdef READOUT_TIMESTAMP_EN
        wr_entry_c.ts  = ts_cnt;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            raw_idx <= '0;
            dec_cnt <= '0;
            dec_lim <= '0;
        end else if (done_i) begin
            raw_idx <= raw_idx + SEQW'(1);
            dec_cnt <= (dec_cnt == lim_now_c) ? '0 : dec_cnt + DECW'(1);
            if (keep_c) begin
                dec_lim <= lim_now_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            overflow_o <= 1'b0;
            drops_o    <= '0;
        end else if (drop_c) begin
            overflow_o <= 1'b1;
            if (drops_o != 16'hFFFF) begin
                drops_o <= drops_o + 16'd1;
            end
        end
    end

    sync_fifo #(
        .T     (readout_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (clr_i),
        .push    (push_c),
        .pop     (pop_c),
        .wdata   (wr_entry_c),
        .head_c  (head_c),
        .full_c  (full_c),
        .empty_c (empty_c),
        .level   (level_o)
    );

    // Read FSM next state; pop only when there is something to hand out.
    always_comb begin
        state_d = state;
        pop_c   = 1'b0;
        case (state)
            IDLE: begin
                if (rd_tgl_i != rd_tgl_q) begin
                    state_d = POP;
                end
            end
            POP: begin
                pop_c   = !empty_c;
                state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // rd_tgl_q only follows the request in IDLE, so toggles during POP/ACK queue up.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rd_tgl_q <= 1'b0;
            rd_ack_o <= 1'b0;
            x_o      <= '0;
            y_o      <= '0;
            seq_o    <= '0;
            valid_o  <= 1'b0;
`ifdef READOUT_TIMESTAMP_EN
            ts_o     <= '0;
`endif
        end else begin
            state <= state_d;
            if (state == IDLE) begin
                rd_tgl_q <= rd_tgl_i;
            end
            if (state == POP) begin
                valid_o <= !empty_c;
                if (!empty_c) begin
                    x_o   <= 32'(head_c.x);
                    y_o   <= 32'(head_c.y);
                    seq_o <= head_c.seq;
`ifdef READOUT_TIMESTAMP_EN
                    ts_o  <= head_c.ts;
`endif
                end
            end
            if (state == ACK) begin
                rd_ack_o <= rd_tgl_q;
            end
        end
    end

endmodule

// File: tb/tb_lockin_readout_ctrl.sv
// Randomized and directed bench for lockin_readout_ctrl against a queue-based model.
// Honours READOUT_TIMESTAMP_EN the same way as the design.
`timescale 1ns/1ps
module tb_lockin_readout_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = 24;
    localparam int unsigned DECW  = 16;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic            clk;
    logic            reset;
    logic            done_i;
    logic [DW-1:0]   x_i;
    logic [DW-1:0]   y_i;
    logic [DECW-1:0] decim_i;
    logic            clr_i;
    logic            rd_tgl_i;
    logic            rd_ack_o;
    logic [31:0]     x_o;
    logic [31:0]     y_o;
    logic [31:0]     seq_o;
    logic            valid_o;
    logic [LW-1:0]   level_o;
    logic            overflow_o;
    logic [15:0]     drops_o;
    logic [31:0]     ts_o;

    lockin_readout_ctrl #(.DEPTH(DEPTH), .DW(DW), .DECW(DECW)) dut (
        .clk        (clk),
        .reset      (reset),
        .done_i     (done_i),
        .x_i        (x_i),
        .y_i        (y_i),
        .decim_i    (decim_i),
        .clr_i      (clr_i),
        .rd_tgl_i   (rd_tgl_i),
        .rd_ack_o   (rd_ack_o),
        .x_o        (x_o),
        .y_o        (y_o),
        .seq_o      (seq_o),
        .valid_o    (valid_o),
        .level_o    (level_o),
        .overflow_o (overflow_o),
        .drops_o    (drops_o),
        .ts_o       (ts_o)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] seq;
        logic [31:0] ts;
    } ent_t;

    ent_t        q[$];
    ent_t        last;
    bit          last_v;
    logic [31:0] raw;
    int unsigned remain;
    bit          ovf;
    int unsigned drops;
    logic [31:0] tb_cyc;
    bit          tgl;
    int          n_checks;
    int          n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset release, i.e. the timestamp a push in this cycle carries.
    always @(posedge clk) tb_cyc <= reset ? 32'd0 : tb_cyc + 32'd1;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sext(logic [DW-1:0] v);
        logic signed [DW-1:0] s;
        int                   i;
        s = v;
        i = s;
        return 32'(i);
    endfunction

    task automatic model_done(logic [DW-1:0] x, logic [DW-1:0] y, logic [DECW-1:0] d, bit clr);
        bit keep;
        keep = (remain == 0);
        if (keep) remain = (d == '0) ? 0 : 32'(d) - 1;
        else remain--;
        if (keep && !clr) begin
            if (q.size() >= int'(DEPTH)) begin
                ovf = 1'b1;
                if (drops < 65535) drops++;
            end else begin
                q.push_back('{sext(x), sext(y), raw, tb_cyc});
            end
        end
        raw++;
    endtask

    task automatic model_pop();
        if (q.size() > 0) begin
            last   = q.pop_front();
            last_v = 1'b1;
        end else begin
            last_v = 1'b0;
        end
    endtask

    task automatic step(bit d, bit c, logic [DW-1:0] x, logic [DW-1:0] y);
        done_i = d;
        clr_i  = c;
        x_i    = x;
        y_i    = y;
        if (d) model_done(x, y, decim_i, c);
        if (c) begin
            q.delete();
            ovf   = 1'b0;
            drops = 0;
        end
        tick();
        done_i = 1'b0;
        clr_i  = 1'b0;
    endtask

    task automatic check_out(string tag);
        check({tag, ".x"}, x_o, last.x);
        check({tag, ".y"}, y_o, last.y);
        check({tag, ".seq"}, seq_o, last.seq);
        check({tag, ".valid"}, 32'(valid_o), 32'(last_v));
`ifdef READOUT_TIMESTAMP_EN
        check({tag, ".ts"}, ts_o, last.ts);
`else
        check({tag, ".ts"}, ts_o, 32'd0);
`endif
    endtask

    task automatic check_stats(string tag);
        check({tag, ".level"}, 32'(level_o), 32'(q.size()));
        check({tag, ".ovf"}, 32'(overflow_o), 32'(ovf));
        check({tag, ".drops"}, 32'(drops_o), drops);
    endtask

    task automatic check_zero(string tag);
        check({tag, ".x"}, x_o, 32'd0);
        check({tag, ".y"}, y_o, 32'd0);
        check({tag, ".seq"}, seq_o, 32'd0);
        check({tag, ".ts"}, ts_o, 32'd0);
        check({tag, ".valid"}, 32'(valid_o), 32'd0);
        check({tag, ".ack"}, 32'(rd_ack_o), 32'd0);
        check({tag, ".level"}, 32'(level_o), 32'd0);
        check({tag, ".ovf"}, 32'(overflow_o), 32'd0);
        check({tag, ".drops"}, 32'(drops_o), 32'd0);
    endtask

    // Software read: toggle, optionally push a result during the POP cycle, wait for ack.
    task automatic sw_read(bit co, logic [DW-1:0] cx, logic [DW-1:0] cy);
        int n;
        n = 0;
        model_pop();
        tgl      = ~tgl;
        rd_tgl_i = tgl;
        if (co) begin
            tick();
            n++;
            done_i = 1'b1;
            x_i    = cx;
            y_i    = cy;
            model_done(cx, cy, decim_i, 1'b0);
            tick();
            n++;
            done_i = 1'b0;
        end
        while (rd_ack_o !== tgl && n < 10) begin
            tick();
            n++;
        end
        check("rd.ack", 32'(rd_ack_o), 32'(tgl));
        check("rd.ack_lat", 32'(n), 32'd3);
        check_out("rd");
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        done_i   = 1'b0;
        clr_i    = 1'b0;
        rd_tgl_i = 1'b0;
        x_i      = '0;
        y_i      = '0;
        tgl      = 1'b0;
        tick();
        tick();
        reset  = 1'b0;
        q.delete();
        raw    = '0;
        remain = 0;
        ovf    = 1'b0;
        drops  = 0;
        last   = '{32'd0, 32'd0, 32'd0, 32'd0};
        last_v = 1'b0;
    endtask

    initial begin
        bit          prev;
        int          chg;
        int unsigned r;
        int unsigned len;

        n_checks = 0;
        n_pass   = 0;
        decim_i  = 16'd1;
        do_reset();
        check_zero("reset");

        // Basic ordering and sign extension.
        step(1'b1, 1'b0, 24'd5, 24'd1);
        step(1'b1, 1'b0, 24'hFFFFF9, 24'd2);
        step(1'b1, 1'b0, 24'd100000, 24'd3);
        sw_read(1'b0, '0, '0);
        check("t1.x0", x_o, 32'd5);
        sw_read(1'b0, '0, '0);
        check("t1.x1", x_o, 32'hFFFFFFF9);
        sw_read(1'b0, '0, '0);
        check("t1.x2", x_o, 32'd100000);
        check("t1.seq2", seq_o, 32'd2);

        // Decimation by 4, then a read from an empty FIFO holds the data.
        do_reset();
        decim_i = 16'd4;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, DW'(i + 11), DW'(i + 21));
        check("t2.level", 32'(level_o), 32'd3);
        for (int i = 0; i < 4; i++) sw_read(1'b0, '0, '0);
        check("t2.seq_held", seq_o, 32'd8);
        check("t2.valid", 32'(valid_o), 32'd0);

        // Overflow, drop counting and clear.
        do_reset();
        decim_i = 16'd1;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, DW'($urandom), DW'($urandom));
        check_stats("t3.full");
        check("t3.drops", 32'(drops_o), 32'd4);
        step(1'b0, 1'b1, '0, '0);
        check_stats("t3.clr");

        // Push coincident with the pop of a full FIFO.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'($urandom), DW'($urandom));
        sw_read(1'b1, 24'h0ABCDE, 24'h012345);
        check_stats("t4.co");
        for (int i = 0; i < 16; i++) sw_read(1'b0, '0, '0);
        check("t4.last_seq", seq_o, 32'd16);
        check("t4.last_x", x_o, 32'h000ABCDE);

        // Two toggles back to back, then reset while in POP.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(24'h123456 + i), DW'(24'h654321 + i));
        model_pop();
        model_pop();
        tgl      = ~tgl;
        rd_tgl_i = tgl;
        tick();
        tgl      = ~tgl;
        rd_tgl_i = tgl;
        prev     = rd_ack_o;
        chg      = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rd_ack_o !== prev) chg++;
            prev = rd_ack_o;
        end
        check("t5.ack_changes", 32'(chg), 32'd2);
        check("t5.ack_final", 32'(rd_ack_o), 32'(rd_tgl_i));
        check_out("t5");
        check_stats("t5");
        tgl      = ~tgl;
        rd_tgl_i = tgl;
        tick();
        reset = 1'b1;
        tick();
        check_zero("t5.midpop");
        do_reset();

`ifdef READOUT_TIMESTAMP_EN
        // Timestamps of pushes 10 and 25 cycles after reset release.
        decim_i = 16'd1;
        for (int i = 0; i < 10; i++) tick();
        step(1'b1, 1'b0, 24'd1, 24'd2);
        for (int i = 0; i < 14; i++) tick();
        step(1'b1, 1'b0, 24'd3, 24'd4);
        sw_read(1'b0, '0, '0);
        check("ts.first", ts_o, 32'd10);
        sw_read(1'b0, '0, '0);
        check("ts.second", ts_o, 32'd25);
        do_reset();
`endif

        // Randomized traffic with varying decimation, reads and clears.
        decim_i = 16'd1;
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                len = $urandom_range(1, 12);
                for (int k = 0; k < int'(len); k++)
                    step(1'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0),
                         DW'($urandom), DW'($urandom));
            end else if (r < 8) begin
                sw_read(1'b0, '0, '0);
            end else if (r == 8) begin
                decim_i = DECW'($urandom_range(0, 5));
            end else begin
                sw_read(1'b1, DW'($urandom), DW'($urandom));
            end
            check_stats("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lockin_readout_ctrl.md
Name: lockin_readout_ctrl

Overview:
Sequences lock-in results toward the processor-facing output registers, replacing the direct x/y/counter assignment. Decimates the lock-in result stream by a programmable factor and tags each kept result with a sequence number. Buffers results in a small FIFO and serves them to software through a toggle request/acknowledge handshake over GPIO registers. Sits between the lock-in amplifier (done/x/y) and the oreg outputs of the top level.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2
DW, 24, lock-in result width (signed)
DECW, 16, decimation-factor width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
done_i  in  1  one-cycle lock-in result strobe
x_i  in  DW  signed in-phase result, valid when done_i=1
y_i  in  DW  signed quadrature result, valid when done_i=1
decim_i  in  DECW  keep 1 of every N results; 0 is treated as 1
clr_i  in  1  one-cycle pulse: flush FIFO, clear overflow and drop count
rd_tgl_i  in  1  software read request; each level change requests one pop
rd_ack_o  out  1  equals rd_tgl_i once the request has been serviced
x_o  out  32  sign-extended x of the presented entry
y_o  out  32  sign-extended y of the presented entry
seq_o  out  32  raw result index of the presented entry
valid_o  out  1  1 when the presented entry came from a non-empty FIFO
level_o  out  $clog2(DEPTH)+1  current FIFO fill level
overflow_o  out  1  sticky; set when a kept result is dropped
drops_o  out  16  saturating count of dropped results
ts_o  out  32  timestamp of the presented entry (see Optional Feature)

Behaviour:
- Reset values: all outputs 0. FIFO empty, decimation counter 0, raw index 0, rd_tgl_q 0.
- Raw index increments on every done_i, wrapping at 2^32, whether or not the result is kept.
- Decimation counter: on each done_i the result is kept when the counter is 0. The counter then advances and wraps to 0 after reaching max(decim_i,1)-1. A change to decim_i takes effect at the next wrap.
- Push: a kept result writes {x_i, y_i, raw index before increment} in the same cycle. The entry is readable from the FIFO on the next cycle.
- Full with no pop in the same cycle: the result is dropped, overflow_o is set, and drops_o increments, saturating at 0xFFFF.
- Full with a pop in the same cycle: both the push and the pop proceed; no drop.
- Read FSM states and transitions:
  - IDLE: registers rd_tgl_i into rd_tgl_q. A difference between rd_tgl_i and rd_tgl_q moves the FSM to POP.
  - POP (1 cycle): if the FIFO is non-empty, load the head into the x_o/y_o/seq_o/ts_o registers, set valid_o=1, and pop. If empty, hold the data registers and set valid_o=0. Then move to ACK.
  - ACK (1 cycle): rd_ack_o <= rd_tgl_q, then return to IDLE.
- Latency: a toggle first visible at cycle N produces data at N+2 and rd_ack_o at N+3. Software reads the outputs once rd_ack_o equals its own toggle value.
- Toggles arriving while in POP or ACK are not lost. They are detected on return to IDLE because rd_tgl_q is only updated in IDLE.
- clr_i: flushes the FIFO and clears overflow_o and drops_o. It does not alter the FSM, the presented outputs, the raw index, or the decimation counter. A push in the same cycle as clr_i is discarded.
- Reset mid-operation returns the block to the reset state. rd_ack_o returns to 0, so software must also reset its toggle to 0.

Optional Feature:
READOUT_TIMESTAMP_EN
- Defined: a 32-bit free-running cycle counter (reset 0, wraps) is stored with each pushed entry and presented on ts_o, widening the FIFO entry.
- Undefined: no counter is built, the FIFO entry excludes the timestamp, and ts_o is constant 0.

Decomposition:
- Shared package lockin_pkg holds:
  - DW and SEQW=32 constants
  - typedef struct packed readout_entry_t {x, y, seq[, ts]}
  - enum rd_state_t {IDLE, POP, ACK}
- One sub-module, sync_fifo: parameterised on the entry type and DEPTH, with push, pop, full, empty, level and flush. The decimation logic and read FSM stay in lockin_readout_ctrl.

Test Plan:
- decim_i=1; 3 done_i with x=5,-7,100000, y=1,2,3; toggle rd_tgl_i 3 times -> x_o=5, 0xFFFFFFF9, 100000; seq_o=0,1,2; valid_o=1 each; rd_ack_o follows each toggle 3 cycles after it is seen.
- decim_i=4; 10 done_i -> level_o=3 (seq 0,4,8); pops return seq_o 0,4,8; a 4th toggle gives valid_o=0 with data held.
- DEPTH=16, decim_i=1; 20 done_i with no reads -> level_o=16, overflow_o=1, drops_o=4; then clr_i -> level_o=0, overflow_o=0, drops_o=0.
- Full FIFO with done_i and the POP cycle coincident -> no drop; level_o stays 16; the pushed entry is last in order.
- Toggle twice within 2 cycles -> two pops serviced; final rd_ack_o equals rd_tgl_i. Reset asserted mid-POP -> all outputs 0 next cycle.
- With READOUT_TIMESTAMP_EN: done_i at cycles 10 and 25 after reset -> ts_o reads 10 then 25. Without the macro -> ts_o=0.
